// File: rtl/histogram_sequencer_if.sv
// Pixel-in / bin-out stream bundle for histogram_sequencer.
// The slave modport is the sequencer side; master is the producer/consumer side.
interface histogram_sequencer_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) ();
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] bin_idx;
    logic [CNT_W-1:0] bin_count;
    logic             bin_valid;
    logic             bin_ready;
    logic             bin_last;

    modport slave (
        input  pix_data, pix_valid, bin_ready,
        output pix_ready, bin_idx, bin_count, bin_valid, bin_last
    );

    modport master (
        output pix_data, pix_valid, bin_ready,
        input  pix_ready, bin_idx, bin_count, bin_valid, bin_last
    );
endinterface

// File: rtl/histogram_sequencer.sv
// Clear / accumulate / read out a 2^PIX_W-bin pixel histogram for one frame.
// Optional macro HIST_SATURATE_EN: counts clamp at all-ones instead of wrapping.
module histogram_sequencer #(
    parameter int PIX_W         = 8,
    parameter int CNT_W         = 16,
    parameter int PIX_PER_FRAME = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    histogram_sequencer_if.slave io
);
    localparam int BINS = 1 << PIX_W;
    localparam int PC_W = $clog2(PIX_PER_FRAME + 1);
    localparam logic [PIX_W-1:0] FIRST_BIN = '0;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, READOUT} state_t;

    state_t           state;
    logic [PIX_W-1:0] clr_idx;
    logic [PC_W-1:0]  pix_cnt;
    logic             s1_valid;
    logic [PIX_W-1:0] s1_idx;
    logic [CNT_W-1:0] s1_val;
    logic             pix_ready_r;
    logic [PIX_W-1:0] bin_idx_r;
    logic [CNT_W-1:0] bin_count_r;
    logic             bin_valid_r;
    logic             bin_last_r;
    logic             busy_r;
    logic             done_r;

    logic [CNT_W-1:0] bin_mem [BINS];

    logic             pix_fire;
    logic [CNT_W-1:0] s1_next;
    logic [CNT_W-1:0] rd_pix;
    logic [CNT_W-1:0] rd_first;
    logic [PIX_W-1:0] next_idx;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef HIST_SATURATE_EN
        return (v == '1) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    // Stage-2 result bypasses the memory for a same-bin read in the following cycle.
    always_comb begin
        pix_fire = io.pix_valid & pix_ready_r;
        s1_next  = bump(s1_val);
        rd_pix   = (s1_valid && s1_idx == io.pix_data) ? s1_next : bin_mem[io.pix_data];
        rd_first = (s1_valid && s1_idx == FIRST_BIN) ? s1_next : bin_mem[FIRST_BIN];
        next_idx = bin_idx_r + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            bin_mem[s1_idx] <= s1_next;
        end else if (state == CLEAR) begin
            bin_mem[clr_idx] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            clr_idx     <= '0;
            pix_cnt     <= '0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            s1_val      <= '0;
            pix_ready_r <= 1'b0;
            bin_idx_r   <= '0;
            bin_count_r <= '0;
            bin_valid_r <= 1'b0;
            bin_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            s1_valid <= pix_fire;
            if (pix_fire) begin
                s1_idx <= io.pix_data;
                s1_val <= rd_pix;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == '1) begin
                        state       <= ACCUM;
                        pix_cnt     <= '0;
                        pix_ready_r <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (pix_fire) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == PC_W'(PIX_PER_FRAME - 1)) begin
                            state       <= DRAIN;
                            pix_ready_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state       <= READOUT;
                    bin_idx_r   <= '0;
                    bin_count_r <= rd_first;
                    bin_valid_r <= 1'b1;
                    bin_last_r  <= 1'b0;
                end
                READOUT: begin
                    if (io.bin_ready) begin
                        if (bin_last_r) begin
                            state       <= IDLE;
                            bin_valid_r <= 1'b0;
                            bin_last_r  <= 1'b0;
                            bin_idx_r   <= '0;
                            bin_count_r <= '0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            bin_idx_r   <= next_idx;
                            bin_count_r <= bin_mem[next_idx];
                            bin_last_r  <= (next_idx == '1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign io.pix_ready = pix_ready_r;
    assign io.bin_idx   = bin_idx_r;
    assign io.bin_count = bin_count_r;
    assign io.bin_valid = bin_valid_r;
    assign io.bin_last  = bin_last_r;
endmodule

// File: tb/tb_histogram_sequencer.sv
// Scoreboard bench for histogram_sequencer: a default-size instance plus a
// narrow-counter instance for overflow behaviour.
module tb_histogram_sequencer;
    localparam int PIX_W = 8, CNT_W = 16, PPF = 64, BINS = 256;
    localparam int S_PIX_W = 3, S_CNT_W = 4, S_PPF = 20, S_BINS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, busy, done;
    logic s_start, s_busy, s_done;

    histogram_sequencer_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) hif ();
    histogram_sequencer_if #(.PIX_W(S_PIX_W), .CNT_W(S_CNT_W)) sif ();

    histogram_sequencer #(.PIX_W(PIX_W), .CNT_W(CNT_W), .PIX_PER_FRAME(PPF)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .io(hif.slave));

    histogram_sequencer #(.PIX_W(S_PIX_W), .CNT_W(S_CNT_W), .PIX_PER_FRAME(S_PPF)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done), .io(sif.slave));

    typedef struct {
        int unsigned idx;
        int unsigned cnt;
        bit          last;
    } bin_t;

    bin_t        exp_q[$];
    bin_t        s_exp_q[$];
    int unsigned frame[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned done_seen = 0;
    int unsigned s_done_seen = 0;
    bit          expect_done = 1'b0;
    bit          s_expect_done = 1'b0;
    int          rdy_mode = 0;

    function automatic int unsigned bump(input int unsigned v, input int cw);
        int unsigned top;
        top = (32'd1 << cw) - 1;
`ifdef HIST_SATURATE_EN
        return (v >= top) ? top : v + 1;
`else
        return (v + 1) & top;
`endif
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference histogram of the current frame, pushed as the full readout sequence.
    task automatic push_expected();
        int unsigned h[BINS];
        bin_t b;
        foreach (h[i]) h[i] = 0;
        foreach (frame[i]) h[frame[i]] = bump(h[frame[i]], CNT_W);
        for (int i = 0; i < BINS; i++) begin
            b.idx = i; b.cnt = h[i]; b.last = (i == BINS - 1);
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        #1;
        hif.bin_ready = (rdy_mode == 1) ? ~hif.bin_ready : 1'b1;
    end

    // Main-instance monitor: every presented bin is compared with the queue head.
    always @(negedge clk) begin
        bin_t e;
        if (expect_done) begin
            check("done_pulse", done, 1);
            check("busy_low_at_done", busy, 0);
            expect_done = 1'b0;
            done_seen++;
        end else if (done) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got 1 expected 0");
        end
        if (hif.bin_valid) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_bin: got idx=%0d expected no output", hif.bin_idx);
            end else begin
                e = exp_q[0];
                tests++;
                if (int'(hif.bin_idx) != int'(e.idx) || int'(hif.bin_count) != int'(e.cnt) ||
                    hif.bin_last != e.last) begin
                    fails++;
                    $display("FAIL bin_out: got idx=%0d cnt=%0d last=%0d expected idx=%0d cnt=%0d last=%0d",
                             hif.bin_idx, hif.bin_count, hif.bin_last, e.idx, e.cnt, e.last);
                end
                if (hif.bin_ready) begin
                    void'(exp_q.pop_front());
                    if (e.last) expect_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bin_t e;
        if (s_expect_done) begin
            check("small_done_pulse", s_done, 1);
            s_expect_done = 1'b0;
            s_done_seen++;
        end
        if (sif.bin_valid) begin
            if (s_exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL small_unexpected_bin: got idx=%0d expected no output", sif.bin_idx);
            end else begin
                e = s_exp_q.pop_front();
                tests++;
                if (int'(sif.bin_idx) != int'(e.idx) || int'(sif.bin_count) != int'(e.cnt)) begin
                    fails++;
                    $display("FAIL small_bin_out: got idx=%0d cnt=%0d expected idx=%0d cnt=%0d",
                             sif.bin_idx, sif.bin_count, e.idx, e.cnt);
                end
                if (e.last) s_expect_done = 1'b1;
            end
        end
    end

    task automatic start_run(input bit junk);
        int n;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; n = 1;
        if (junk) begin
            hif.pix_valid = 1'b1;
            hif.pix_data  = 8'd200;
        end
        @(negedge clk);
        check("busy_in_clear", busy, 1);
        while (n < 400 && !hif.pix_ready) begin
            @(posedge clk); n++;
            @(negedge clk);
        end
        check("start_to_ready_cycles", n, BINS + 1);
        hif.pix_valid = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int i, guard;
        bit acc;
        i = 0; guard = 0;
        @(posedge clk); #1;
        hif.pix_valid = 1'b1;
        hif.pix_data  = PIX_W'(frame[0]);
        while (i < n && guard < 2000) begin
            @(negedge clk);
            acc = hif.pix_valid && hif.pix_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) i++;
            if (i < n) begin
                hif.pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                hif.pix_data  = hif.pix_valid ? PIX_W'(frame[i]) : PIX_W'($urandom);
            end else begin
                hif.pix_valid = 1'b0;
            end
        end
        check("pixels_accepted", i, n);
    endtask

    task automatic drain_timing();
        @(negedge clk);
        check("ready_drop_after_frame", hif.pix_ready, 0);
        check("no_valid_in_drain", hif.bin_valid, 0);
        @(negedge clk);
        check("valid_after_drain", hif.bin_valid, 1);
    endtask

    task automatic wait_done(input int unsigned target);
        int guard;
        guard = 0;
        while (done_seen < target && guard < 3000) begin
            @(negedge clk); guard++;
        end
        check("run_complete", done_seen, target);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic full_run(input bit gaps);
        push_expected();
        start_run(1'b0);
        feed(PPF, gaps);
        drain_timing();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned h;
        int guard, acc_n;
        bin_t b;
        rst = 1'b1; start = 1'b0; s_start = 1'b0;
        hif.pix_valid = 1'b0; hif.pix_data = '0;
        sif.pix_valid = 1'b0; sif.pix_data = '0; sif.bin_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pix_ready", hif.pix_ready, 0);
        check("rst_bin_valid", hif.bin_valid, 0);
        check("rst_bin_last", hif.bin_last, 0);
        check("rst_done", done, 0);
        check("rst_bin_idx", hif.bin_idx, 0);
        check("rst_bin_count", hif.bin_count, 0);
        @(posedge clk); #1; rst = 1'b0;

        frame.delete();
        for (int i = 0; i < PPF; i++) frame.push_back(i);
        full_run(1'b0);
        wait_done(1);

        frame.delete();
        for (int i = 0; i < PPF; i++) frame.push_back(8'hA5);
        full_run(1'b0);
        wait_done(2);

        frame.delete();
        for (int i = 0; i < PPF; i++) frame.push_back($urandom_range(0, 15));
        full_run(1'b0);
        wait_done(3);
        rdy_mode = 1;
        full_run(1'b1);
        wait_done(4);
        rdy_mode = 0;

        // Junk pixel during CLEAR and a start pulse during READOUT must be ignored.
        frame.delete();
        for (int i = 0; i < PPF; i++) frame.push_back($urandom_range(0, 127));
        push_expected();
        start_run(1'b1);
        feed(PPF, 1'b0);
        drain_timing();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(5);
        @(negedge clk);
        check("start_ignored_in_readout", busy, 0);

        frame.delete();
        for (int i = 0; i < 30; i++) frame.push_back($urandom_range(0, 255));
        start_run(1'b0);
        feed(30, 1'b0);
        hif.pix_valid = 1'b1; hif.pix_data = 8'd5;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_pix_ready", hif.pix_ready, 0);
        check("midrun_rst_bin_valid", hif.bin_valid, 0);
        #1; hif.pix_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;

        frame.delete();
        for (int i = 0; i < PPF; i++) frame.push_back(3);
        full_run(1'b0);
        wait_done(6);

        h = 0;
        for (int i = 0; i < S_PPF; i++) h = bump(h, S_CNT_W);
        for (int i = 0; i < S_BINS; i++) begin
            b.idx = i; b.cnt = (i == 7) ? h : 0; b.last = (i == S_BINS - 1);
            s_exp_q.push_back(b);
        end
        @(posedge clk); #1; s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        sif.pix_valid = 1'b1; sif.pix_data = 3'd7;
        acc_n = 0; guard = 0;
        while (acc_n < S_PPF && guard < 200) begin
            @(negedge clk);
            if (sif.pix_ready) acc_n++;
            @(posedge clk); #1;
            guard++;
            if (acc_n == S_PPF) sif.pix_valid = 1'b0;
        end
        check("small_pixels_accepted", acc_n, S_PPF);
        guard = 0;
        while (s_done_seen < 1 && guard < 200) begin
            @(negedge clk); guard++;
        end
        check("small_run_complete", s_done_seen, 1);
        check("small_scoreboard_empty", s_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/histogram_sequencer.md
# histogram_sequencer

Sequential controller for the JPEG decoder's pixel-histogram path. It clears a 2^PIX_W-bin count memory, accepts a frame of PIX_PER_FRAME pixels over a valid/ready stream, and increments one bin per accepted pixel through a two-stage read-modify-write pipeline. It then streams all bins out in index order over a second valid/ready port. It sits between the decoded-pixel stream and downstream statistics consumers.

## Interface
- PIX_W, 8, pixel width; bin count = 2^PIX_W
- CNT_W, 16, bin counter width
- PIX_PER_FRAME, 64, pixels accepted per run (one 8x8 block by default); must be ≥ 1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- pix_data  in  PIX_W  pixel value = bin index
- pix_valid  in  1  pixel present
- pix_ready  out  1  high only in ACCUM
- bin_idx  out  PIX_W  bin index being presented
- bin_count  out  CNT_W  count of bin_idx
- bin_valid  out  1  bin output present
- bin_ready  in  1  consumer accepts bin
- bin_last  out  1  high with bin_idx = 2^PIX_W-1
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, READOUT.
- **IDLE**
  - start=1 → CLEAR with clear index 0.
  - start is ignored in all other states.
- **CLEAR**
  - Writes 0 to one bin per cycle, indices 0..2^PIX_W-1.
  - After the last write → ACCUM, with the pixel counter at 0.
- **ACCUM**
  - A pixel is accepted on pix_valid & pix_ready.
  - Stage 1 reads bin[pix_data]. Stage 2 writes the incremented value.
  - Back-to-back pixels hitting the same bin forward the stage-2 result, so there are no lost increments.
  - Accepting pixel number PIX_PER_FRAME → DRAIN. pix_ready drops the following cycle.
- **DRAIN**
  - One cycle; retires the final write → READOUT with index 0.
- **READOUT**
  - bin_valid=1. bin_idx/bin_count/bin_last hold stable while bin_ready=0.
  - On handshake the index increments.
  - Handshake with bin_last=1 → IDLE. done pulses for one cycle and busy=0 in that same cycle.
- **Counter width**
  - Increment is modulo 2^CNT_W by default; see Configuration.
- **Reset**
  - rst at any time, including mid-run, forces IDLE the next cycle.
  - Output reset values: busy=0, pix_ready=0, bin_valid=0, bin_last=0, done=0, bin_idx=0, bin_count=0.
  - The bin memory is not reset; CLEAR guarantees zero contents at the start of every run.
- **Pixel handling**
  - pix_valid outside ACCUM is ignored; no pixel is consumed.

## Timing
- **Start to ACCUM:** start sampled at cycle t. CLEAR occupies t+1 .. t+2^PIX_W. pix_ready=1 from cycle t+2^PIX_W+1.
- **Increment latency:** a pixel accepted at cycle k is written at k+1. The result is readable by the pipeline, via forwarding, at k+1.
- **ACCUM to READOUT:** last pixel accepted at k. DRAIN at k+1. bin_valid=1 with bin_idx=0 at k+2.
- **Readout throughput:** one bin per cycle with bin_ready held high.
- **Minimum run length:** 2^PIX_W + PIX_PER_FRAME + 2^PIX_W + 2 cycles from start to done, with no stalls.

## Configuration
- HIST_SATURATE_EN
  - Defined: increments clamp at 2^CNT_W-1.
  - Undefined: counts wrap modulo 2^CNT_W.
  - Forwarding honours the selected rule in both cases.

## Test plan
- **Uniform frame:** reset, start, feed 64 pixels 0..63 with pix_valid held high → readout bins 0..63 = 1, bins 64..255 = 0; bin_last on idx 255; done one cycle after that handshake.
- **Same-bin burst:** 64 consecutive pixels of value 0xA5 → bin 0xA5 = 64, all other bins = 0. This proves forwarding.
- **Stalls on both ports:** random pix_valid gaps, and bin_ready toggled every other cycle → counts identical to the no-stall run; bin_idx/bin_count stable during every stall.
- **Overflow:** CNT_W=4, 20 pixels of value 7 → bin 7 = 4 without HIST_SATURATE_EN; bin 7 = 15 with it.
- **Reset mid-run and rerun:**
  - rst asserted during ACCUM after 30 pixels → next cycle busy=0, pix_ready=0, bin_valid=0.
  - A following run of 64 pixels of value 3 → bin 3 = 64 and no stale counts.
- **Spurious inputs:** start pulsed during READOUT, and pix_valid asserted during CLEAR → both ignored; run results unchanged.
